// File: rtl/dma_io_peripheral.sv
// ---------------------------------------------------------------------------
// dma_io_peripheral
//
// Device end of a DMAC DREQ/DACK/IOR/IOW/RDY/EOP handshake, backed by a byte
// FIFO.
//   dir_q = 1 : device -> memory. The local side pushes (DEV_WR) and the DMAC
//               drains with IOR; the head is driven on Data_out.
//   dir_q = 0 : memory -> device. The DMAC fills with IOW (Data_in) and the
//               local side drains with DEV_RD.
// The device raises DREQ while it can make progress. It inserts WAIT_CYCLES
// wait states on RDY after every completed transfer, and it stops on EOP.
//
// Handshake: in XFER, a DMA beat is offered when DACK is high together with
// the strobe that matches dir_q (IOR when dir_q=1, IOW when dir_q=0). RDY is
// the ready. The beat completes in the cycle where the offer and RDY are both
// high. RDY is forced low while the FIFO cannot serve the offered beat (empty
// on a read, full on a write), and it stays low until the FIFO can serve it.
// Strobes without DACK, and strobes of the wrong type, never move data.
//
// Parameters
//   DATA_W       data width of the FIFO and both buses
//   DEPTH        FIFO entries (power of two, >= 2)
//   WAIT_CYCLES  RDY-low cycles after each completed transfer (0..15)
//
// Ports
//   CLK, RST_N        clock; asynchronous active-low reset
//   DIR               direction request, sampled only in IDLE
//   DACK/IOR/IOW/EOP  DMAC handshake inputs
//   Data_in/Data_out  DMAC write data in / read data out (0 when not reading)
//   DREQ, RDY         DMA request; ready (low = wait state)
//   DEV_WR/DEV_WDATA  local push (honoured when dir_q=1 and not FULL)
//   DEV_RD/DEV_RDATA  local pop (honoured when dir_q=0 and not EMPTY);
//                     DEV_RDATA is the show-ahead head (0 when empty)
//   FULL, EMPTY       FIFO status
//   dbg_state_o       current FSM state (IDLE=0, REQ=1, XFER=2, DONE=3)
//   XFER_CNT          present only with XFER_CNT_EN: count of transfers
//                     since the last IDLE -> REQ entry
//
// Optional feature macro: XFER_CNT_EN
// ---------------------------------------------------------------------------
module dma_io_peripheral #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              DIR,
  input  logic              DACK,
  input  logic              IOR,
  input  logic              IOW,
  input  logic              EOP,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out,
  output logic              DREQ,
  output logic              RDY,
  input  logic              DEV_WR,
  input  logic [DATA_W-1:0] DEV_WDATA,
  input  logic              DEV_RD,
  output logic [DATA_W-1:0] DEV_RDATA,
  output logic              FULL,
  output logic              EMPTY,
  output logic [1:0]        dbg_state_o
`ifdef XFER_CNT_EN
  ,
  output logic [15:0]       XFER_CNT
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [3:0]    WAIT_C  = WAIT_CYCLES[3:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              dir_q, dir_d;
  logic              dreq_q, dreq_d;
  logic [3:0]        wait_q, wait_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              empty, full;
  logic              in_xfer;
  logic              rd_offer, wr_offer;
  logic              stall, rdy;
  logic              xfer;
  logic              push, pop;
  logic [DATA_W-1:0] wdata;
  logic              want, want_nxt;

  // ---------------- FIFO status and handshake qualification ----------------
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign in_xfer = (state_q == S_XFER);

  // Only the strobe that matches the latched direction counts as an offer.
  assign rd_offer = DACK & IOR &  dir_q;
  assign wr_offer = DACK & IOW & ~dir_q;

  // A beat the FIFO cannot serve holds RDY low combinationally until served.
  assign stall = in_xfer & ((rd_offer & empty) | (wr_offer & full));
  assign rdy   = (state_q == S_DONE) | ((wait_q == 4'd0) & ~stall);
  assign xfer  = in_xfer & rdy & (rd_offer | wr_offer);

  // Per direction there is exactly one producer and one consumer, so at most
  // one push and one pop can happen in any cycle.
  assign push  = dir_q ? (DEV_WR & ~full) : (xfer & ~dir_q);
  assign pop   = dir_q ? (xfer & dir_q)   : (DEV_RD & ~empty);
  assign wdata = dir_q ? DEV_WDATA : Data_in;

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  assign want     = dir_q ? !empty : !full;
  // Looks at the post-update fill level so DREQ drops right after the beat
  // that empties (or fills) the FIFO.
  assign want_nxt = dir_q ? (count_d != '0) : (count_d != DEPTH_C);

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    dreq_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        dir_d = DIR;
        if (want) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (EOP) begin
          state_d = S_DONE;
        end else if (DACK) begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // A beat in the EOP cycle still completes; EOP only steers the FSM.
        if (EOP) begin
          state_d = S_DONE;
        end else if (!DACK) begin
          state_d = want ? S_REQ : S_IDLE;
        end
      end
      S_DONE: begin
        if (!DACK) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_REQ:   dreq_d = 1'b1;
      S_XFER:  dreq_d = want_nxt;
      default: dreq_d = 1'b0;
    endcase
  end

  // Wait-state counter. It runs only while a transfer can still continue, and
  // it is cleared when the transfer ends so that a new request starts ready.
  always_comb begin
    wait_d = wait_q;
    if (state_d != S_XFER && state_d != S_REQ) begin
      wait_d = 4'd0;
    end else if (xfer) begin
      wait_d = WAIT_C;
    end else if (wait_q != 4'd0) begin
      wait_d = wait_q - 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      dreq_q  <= 1'b0;
      wait_q  <= 4'd0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      dreq_q  <= dreq_d;
      wait_q  <= wait_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an empty count hides every entry.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // ---------------- Outputs ----------------
  assign Data_out    = (in_xfer && rd_offer && !empty) ? mem_q[rptr_q] : '0;
  assign DEV_RDATA   = empty ? '0 : mem_q[rptr_q];
  assign DREQ        = dreq_q;
  assign RDY         = rdy;
  assign FULL        = full;
  assign EMPTY       = empty;
  assign dbg_state_o = state_q;

`ifdef XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (state_q == S_IDLE && state_d == S_REQ) begin
      xfer_cnt_d = 16'd0;
    end else if (xfer) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      xfer_cnt_q <= 16'd0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign XFER_CNT = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_dma_io_peripheral.sv
// ---------------------------------------------------------------------------
// tb_dma_io_peripheral
//
// Directed bench for dma_io_peripheral. u_dut0 uses WAIT_CYCLES=0 and u_dut1
// uses WAIT_CYCLES=2; the two instances share clock and reset. Inputs change
// on the falling edge, and outputs are sampled 1 time unit later. Bytes are
// queued in exp_q when they are driven into the FIFO. They are popped and
// compared when they appear on Data_out or DEV_RDATA.
// ---------------------------------------------------------------------------
module tb_dma_io_peripheral;

  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT0 signals (WAIT_CYCLES = 0) ----------------
  logic          dir, dack, ior, iow, eop, dev_wr, dev_rd;
  logic [DW-1:0] data_in, dev_wdata;
  logic [DW-1:0] data_out, dev_rdata;
  logic          dreq, rdy, full, empty;
  logic [1:0]    dbg0;

  // ---------------- DUT1 signals (WAIT_CYCLES = 2) ----------------
  logic          w_dir, w_dack, w_ior, w_iow, w_eop, w_dev_wr, w_dev_rd;
  logic [DW-1:0] w_data_in, w_dev_wdata;
  logic [DW-1:0] w_data_out, w_dev_rdata;
  logic          w_dreq, w_rdy, w_full, w_empty;
  logic [1:0]    dbg1;

`ifdef XFER_CNT_EN
  logic [15:0] xfer_cnt, w_xfer_cnt;
`endif

  dma_io_peripheral #(.DATA_W(DW), .DEPTH(8), .WAIT_CYCLES(0)) u_dut0 (
    .CLK         (clk),
    .RST_N       (rst_n),
    .DIR         (dir),
    .DACK        (dack),
    .IOR         (ior),
    .IOW         (iow),
    .EOP         (eop),
    .Data_in     (data_in),
    .Data_out    (data_out),
    .DREQ        (dreq),
    .RDY         (rdy),
    .DEV_WR      (dev_wr),
    .DEV_WDATA   (dev_wdata),
    .DEV_RD      (dev_rd),
    .DEV_RDATA   (dev_rdata),
    .FULL        (full),
    .EMPTY       (empty),
    .dbg_state_o (dbg0)
`ifdef XFER_CNT_EN
    ,
    .XFER_CNT    (xfer_cnt)
`endif
  );

  dma_io_peripheral #(.DATA_W(DW), .DEPTH(8), .WAIT_CYCLES(2)) u_dut1 (
    .CLK         (clk),
    .RST_N       (rst_n),
    .DIR         (w_dir),
    .DACK        (w_dack),
    .IOR         (w_ior),
    .IOW         (w_iow),
    .EOP         (w_eop),
    .Data_in     (w_data_in),
    .Data_out    (w_data_out),
    .DREQ        (w_dreq),
    .RDY         (w_rdy),
    .DEV_WR      (w_dev_wr),
    .DEV_WDATA   (w_dev_wdata),
    .DEV_RD      (w_dev_rd),
    .DEV_RDATA   (w_dev_rdata),
    .FULL        (w_full),
    .EMPTY       (w_empty),
    .dbg_state_o (dbg1)
`ifdef XFER_CNT_EN
    ,
    .XFER_CNT    (w_xfer_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] sb_pop();
    logic [DW-1:0] v;
    v = '0;
    if (exp_q.size() != 0) v = exp_q.pop_front();
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_dreq(input bit sel);
    int n;
    n = 0;
    while (((sel ? w_dreq : dreq) !== 1'b1) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(sel ? "dreq_wait1" : "dreq_wait0", {31'd0, sel ? w_dreq : dreq}, 32'd1);
  endtask

  // Walks the FSM back to IDLE by answering every pending request with an EOP.
  task automatic park(input bit sel);
    repeat (8) begin
      @(negedge clk);
      if (sel) w_eop = w_dreq;
      else     eop   = dreq;
    end
    @(negedge clk);
    eop   = 1'b0;
    w_eop = 1'b0;
    #1;
    chk(sel ? "park1_dreq" : "park0_dreq", {31'd0, sel ? w_dreq : dreq}, 32'd0);
  endtask

  task automatic dev_push0(input logic [DW-1:0] b, input bit track);
    @(negedge clk);
    dev_wr    = 1'b1;
    dev_wdata = b;
    if (track) exp_q.push_back(b);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    dir = 1'b1; dack = 0; ior = 0; iow = 0; eop = 0; dev_wr = 0; dev_rd = 0;
    data_in = '0; dev_wdata = '0;
    w_dir = 1'b1; w_dack = 0; w_ior = 0; w_iow = 0; w_eop = 0; w_dev_wr = 0; w_dev_rd = 0;
    w_data_in = '0; w_dev_wdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_dreq",  {31'd0, dreq},  32'd0);
    chk("rst_rdy",   {31'd0, rdy},   32'd1);
    chk("rst_dout",  {24'd0, data_out}, 32'd0);
    chk("rst_rdata", {24'd0, dev_rdata}, 32'd0);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_state", {30'd0, dbg0},  32'd0);
`ifdef XFER_CNT_EN
    chk("rst_xcnt",  {16'd0, xfer_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    // dir_q resets to 0, so the device starts out requesting; bring it back to IDLE.
    park(1'b0);
    park(1'b1);

    // ---- T1: device->memory, three bytes drained by IOR ----
    dev_push0(8'h05, 1'b1);
    @(negedge clk); #1;
    chk("t1_dreq_early", {31'd0, dreq}, 32'd0);
    dev_wdata = 8'h0A; exp_q.push_back(8'h0A);
    @(negedge clk); #1;
    chk("t1_dreq_rise", {31'd0, dreq}, 32'd1);
    dev_wdata = 8'h0F; exp_q.push_back(8'h0F);
    @(negedge clk);
    dev_wr = 1'b0; dack = 1'b1; ior = 1'b1;
    #1;
    chk("t1_dout_req", {24'd0, data_out}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t1_dout", {24'd0, data_out}, {24'd0, sb_pop()});
      chk("t1_rdy",  {31'd0, rdy}, 32'd1);
    end
    @(negedge clk);
    dack = 1'b0; ior = 1'b0;
    #1;
    chk("t1_empty", {31'd0, empty}, 32'd1);
    chk("t1_dreq_drop", {31'd0, dreq}, 32'd0);
    chk("t1_dout_off", {24'd0, data_out}, 32'd0);

    // ---- T2: memory->device, fill to FULL, stall on the 9th IOW ----
    @(negedge clk);
    dir = 1'b0;
    wait_dreq(1'b0);
    @(negedge clk);
    dack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      iow = 1'b1;
      data_in = 8'h11 + 8'(i);
      exp_q.push_back(data_in);
      #1;
      chk("t2_rdy_fill", {31'd0, rdy}, 32'd1);
    end
    @(negedge clk);
    data_in = 8'h19;
    #1;
    chk("t2_full", {31'd0, full}, 32'd1);
    chk("t2_stall_a", {31'd0, rdy}, 32'd0);
    @(negedge clk); #1;
    chk("t2_stall_b", {31'd0, rdy}, 32'd0);
    @(negedge clk);
    dev_rd = 1'b1;
    #1;
    chk("t2_stall_c", {31'd0, rdy}, 32'd0);
    chk("t2_pop_head", {24'd0, dev_rdata}, {24'd0, sb_pop()});
    @(negedge clk);
    dev_rd = 1'b0;
    #1;
    chk("t2_unstall", {31'd0, rdy}, 32'd1);
    chk("t2_notfull", {31'd0, full}, 32'd0);
    exp_q.push_back(8'h19);
    @(negedge clk);
    iow = 1'b0;
    #1;
    chk("t2_refull", {31'd0, full}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dev_rd = 1'b1;
      #1;
      chk("t2_drain", {24'd0, dev_rdata}, {24'd0, sb_pop()});
    end
    @(negedge clk);
    dev_rd = 1'b0;
    ior = 1'b1; // wrong strobe for this direction
    #1;
    chk("t2_empty", {31'd0, empty}, 32'd1);
    chk("t2_wrong_dout", {24'd0, data_out}, 32'd0);
    chk("t2_wrong_rdy", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    ior = 1'b0; dack = 1'b0; dir = 1'b1;
    park(1'b0);

    // ---- T3: WAIT_CYCLES=2 on u_dut1 ----
    @(negedge clk);
    w_dev_wr = 1'b1; w_dev_wdata = 8'h41; exp_q.push_back(8'h41);
    @(negedge clk);
    w_dev_wdata = 8'h42; exp_q.push_back(8'h42);
    @(negedge clk);
    w_dev_wr = 1'b0;
    wait_dreq(1'b1);
    @(negedge clk);
    w_dack = 1'b1; w_ior = 1'b1;
    #1;
    chk("t3_dout_req", {24'd0, w_data_out}, 32'd0);
    @(negedge clk); #1;
    chk("t3_rdy0", {31'd0, w_rdy}, 32'd1);
    chk("t3_dout0", {24'd0, w_data_out}, {24'd0, sb_pop()});
    @(negedge clk); #1;
    chk("t3_rdy1", {31'd0, w_rdy}, 32'd0);
    chk("t3_one_pop", {31'd0, w_empty}, 32'd0);
    chk("t3_head", {24'd0, w_dev_rdata}, {24'd0, exp_q[0]});
    @(negedge clk); #1;
    chk("t3_rdy2", {31'd0, w_rdy}, 32'd0);
    @(negedge clk); #1;
    chk("t3_rdy3", {31'd0, w_rdy}, 32'd1);
    chk("t3_dout1", {24'd0, w_data_out}, {24'd0, sb_pop()});
    @(negedge clk);
    w_dack = 1'b0; w_ior = 1'b0;
    #1;
    chk("t3_empty", {31'd0, w_empty}, 32'd1);

    // ---- T4: EOP with three bytes left ----
    for (int i = 0; i < 5; i++) begin
      dev_push0(8'h31 + 8'(i), 1'b1);
    end
    @(negedge clk);
    dev_wr = 1'b0;
    wait_dreq(1'b0);
    @(negedge clk);
    dack = 1'b1; ior = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("t4_dout", {24'd0, data_out}, {24'd0, sb_pop()});
    end
    @(negedge clk);
    ior = 1'b0; eop = 1'b1;
    @(negedge clk);
    eop = 1'b0;
    #1;
    chk("t4_dreq_done", {31'd0, dreq}, 32'd0);
    chk("t4_rdy_done", {31'd0, rdy}, 32'd1);
    chk("t4_head", {24'd0, dev_rdata}, {24'd0, exp_q[0]});
    @(negedge clk); #1;
    chk("t4_dreq_hold", {31'd0, dreq}, 32'd0);
    @(negedge clk);
    dack = 1'b0;
    @(negedge clk); #1;
    chk("t4_dreq_idle", {31'd0, dreq}, 32'd0);
    wait_dreq(1'b0);
    chk("t4_notempty", {31'd0, empty}, 32'd0);
    chk("t4_notfull", {31'd0, full}, 32'd0);
    @(negedge clk);
    dack = 1'b1; ior = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t4_drain", {24'd0, data_out}, {24'd0, sb_pop()});
    end
    @(negedge clk);
    dack = 1'b0; ior = 1'b0;
    #1;
    chk("t4_empty", {31'd0, empty}, 32'd1);

    // ---- T5: asynchronous reset during XFER ----
    dev_push0(8'h51, 1'b0);
    dev_push0(8'h52, 1'b0);
    @(negedge clk);
    dev_wr = 1'b0;
    wait_dreq(1'b0);
    @(negedge clk);
    dack = 1'b1;
    @(negedge clk);
    ior = 1'b1;
    #1;
    chk("t5_dout_pre", {24'd0, data_out}, 32'h51);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_dreq", {31'd0, dreq}, 32'd0);
    chk("t5_rdy", {31'd0, rdy}, 32'd1);
    chk("t5_empty", {31'd0, empty}, 32'd1);
    chk("t5_dout", {24'd0, data_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t5_ior_ignored", {24'd0, data_out}, 32'd0);
      chk("t5_still_empty", {31'd0, empty}, 32'd1);
    end
    @(negedge clk);
    dack = 1'b0; ior = 1'b0;
    park(1'b0);

`ifdef XFER_CNT_EN
    // ---- T6: transfer counter ----
    for (int i = 0; i < 4; i++) begin
      dev_push0(8'h61 + 8'(i), 1'b1);
    end
    @(negedge clk);
    dev_wr = 1'b0;
    wait_dreq(1'b0);
    @(negedge clk);
    dack = 1'b1; ior = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t6_dout", {24'd0, data_out}, {24'd0, sb_pop()});
    end
    @(negedge clk);
    dack = 1'b0; ior = 1'b0;
    #1;
    chk("t6_cnt4", {16'd0, xfer_cnt}, 32'd4);
    @(negedge clk); #1;
    chk("t6_cnt_hold", {16'd0, xfer_cnt}, 32'd4);
    dev_push0(8'h65, 1'b1);
    @(negedge clk);
    dev_wr = 1'b0;
    wait_dreq(1'b0);
    chk("t6_cnt_clr", {16'd0, xfer_cnt}, 32'd0);
    @(negedge clk);
    dack = 1'b1; ior = 1'b1;
    @(negedge clk); #1;
    chk("t6_dout_last", {24'd0, data_out}, {24'd0, sb_pop()});
    @(negedge clk);
    dack = 1'b0; ior = 1'b0;
    #1;
    chk("t6_cnt1", {16'd0, xfer_cnt}, 32'd1);
`endif

    chk("sb_drained", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
